riscv_bp_cpu: RTL and testbench
===============================

// Module: riscv_bp_cpu
// PURPOSE
//  Single-cycle RV32I-subset core with internal instruction/data memories and a 2-bit branch predictor.
//  Top-level block of the CPU. Only clock and reset cross the boundary.
//  Benches preload memory and registers through hierarchy.
//  Required instance names:
//   - IF: fetch unit; holds reg [31:0] pc and array memory[].
//   - RF: register file; holds registers[0:31].
//   - CU: control unit; holds predict_taken.
//   - Also ID (decode) and ALU.
// PARAMETERS
//  IMEM_DEPTH   256  instruction words in IF.memory; word index = pc>>2, taken modulo depth
//  DMEM_DEPTH   256  data words; word index = addr>>2, taken modulo depth
//  BHT_ENTRIES  16   2-bit counters, indexed by pc[5:2]
// PORTS
//  clk    input  1  system clock, rising edge
//  reset  input  1  synchronous, active-high reset
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - While reset is high at a clk edge:
//    - pc <= 0.
//    - registers[0..31] <= 0.
//    - All BHT counters <= 2'b01 (weakly not-taken).
//    - IF.memory and data memory are NOT reset.
//  - Each non-reset edge executes memory[pc>>2] completely:
//    - register/memory writeback and the next pc commit on the same edge (latency 1 cycle/instr).
//  - Default next pc = pc+4, 32-bit wrap.
//  - x0 reads 0; writes to x0 are discarded.
//  - Supported instructions:
//    - R-type (0110011): ADD, SUB (f7=0100000), AND, OR, XOR, SLL, SRL, SLT.
//    - ADDI (0010011).
//    - LW (0000011).
//    - SW (0100011): any funct3 stores the full word.
//    - BEQ/BNE (1100011).
//    - JAL (1101111): rd <= pc+4.
//  - Arithmetic is 32-bit two's complement, overflow ignored; shifts use rs2[4:0]; SLT is signed.
//  - Immediates are sign-extended. Branch offset: B-type immediate, byte offset relative to pc.
//  - Branch taken -> pc <= pc+imm. Not taken -> pc+4. Offset 0 taken -> pc holds.
//  - All-zero word and every unknown opcode = NOP: pc+4, no state change.
//  - CU.predict_taken (combinational):
//    - For a branch at pc: = BHT[pc[5:2]][1].
//    - 0 for non-branch instructions.
//  - On a branch edge, its counter saturating-increments if taken, else decrements (00..11).
//  - Prediction never alters architectural results; the resolved outcome always decides pc.
//  - Register/memory writes via hierarchy between edges are honoured at the next edge.
// CONFIGURATION
//  BRANCH_PREDICT_EN defined:
//   - BHT as above.
//   - Adds a 32-bit CU.mispredict_count: +1 on each branch whose prediction != outcome; 0 on reset.
//  BRANCH_PREDICT_EN undefined:
//   - No BHT and no counter.
//   - CU.predict_taken is constant 0 (static not-taken).
//   - Architectural behaviour is identical.
// TESTING
//  - Reset, then load x1=1, x2=3 and program:
//    - ADD x3,x1,x2; ADD x4,x3,x1; NOP; SW x4,2(x3); BEQ x1,x2,0.
//    - Run 10 cycles -> x3=4, x4=5.
//    - BEQ not taken; pc advances 0,4,8,...
//  - BEQ x1,x1,+8 at pc=0 -> next pc=8.
//    - predict_taken=0 on first visit.
//    - After two taken executions the counter reads 11 -> predict_taken=1.
//  - SW x2,0(x0) then LW x5,0(x0) with x2=0xDEADBEEF -> x5=0xDEADBEEF.
//  - ADDI x0,x0,5 -> x0 stays 0.
//    - SUB x6,x1,x2 (1-3) -> x6=0xFFFFFFFE.
//    - SLT x7,x6,x1 -> x7=1.
//  - Assert reset mid-program -> next edge pc=0 and all registers 0; memory contents unchanged.
//  - Without BRANCH_PREDICT_EN, a repeated taken branch -> predict_taken stays 0; same register results.

Source files
------------

// File: rtl/riscv_bp_cpu.sv
// riscv_bp_cpu: single-cycle RV32I-subset core (ADD/SUB/AND/OR/XOR/SLL/SRL/SLT,
// ADDI, LW, SW, BEQ/BNE, JAL) with internal instruction and data memories.
// Optional feature macro: BRANCH_PREDICT_EN adds a 2-bit BHT and a mispredict
// counter in the control unit; without it predict_taken is a constant 0.
// Memory depths are assumed to be powers of two (index = address bits above [1:0]).

module riscv_bp_fetch #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  localparam int IAW = $clog2(IMEM_DEPTH);

  logic [31:0] memory [0:IMEM_DEPTH-1];

  assign instr = memory[pc[IAW+1:2]];

  // Program counter: cleared by reset, otherwise takes the resolved next pc.
  always_ff @(posedge clk) begin
    if (reset) pc <= 32'd0;
    else       pc <= next_pc;
  end
endmodule

module riscv_bp_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [0:31];

  assign rd1 = (rs1 == 5'd0) ? 32'd0 : registers[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : registers[rs2];

  // Register writeback; x0 is never written so it always reads back zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
    end else if (we && rd != 5'd0) begin
      registers[rd] <= wd;
    end
  end
endmodule

module riscv_bp_decode (
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_j
);
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

module riscv_bp_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        sub,
  output logic [31:0] y
);
  // Integer operations selected by funct3; subtraction only for funct3 000.
  always_comb begin
    y = 32'd0;
    case (funct3)
      3'b000:  y = sub ? (a - b) : (a + b);
      3'b001:  y = a << b[4:0];
      3'b010:  y = {31'd0, ($signed(a) < $signed(b))};
      3'b100:  y = a ^ b;
      3'b101:  y = a >> b[4:0];
      3'b110:  y = a | b;
      3'b111:  y = a & b;
      default: y = 32'd0;
    endcase
  end
endmodule

module riscv_bp_control #(
  parameter int BHT_ENTRIES = 16,
  parameter int IDXW        = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [IDXW-1:0] bht_idx,
  input  logic            branch_taken,
  output logic            reg_we,
  output logic            mem_we,
  output logic [1:0]      wb_sel,
  output logic            is_branch,
  output logic            is_jal,
  output logic            alu_use_imm,
  output logic            alu_sub,
  output logic [2:0]      alu_f3,
  output logic            predict_taken
);
  logic r_ok;

  assign r_ok = (funct3 != 3'b011) &&
                (funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000));

  // Main decode; anything not recognised falls through as a NOP.
  always_comb begin
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    wb_sel      = 2'd0;
    is_branch   = 1'b0;
    is_jal      = 1'b0;
    alu_use_imm = 1'b0;
    alu_sub     = 1'b0;
    alu_f3      = 3'b000;
    case (opcode)
      7'b0110011: if (r_ok) begin
        reg_we  = 1'b1;
        alu_f3  = funct3;
        alu_sub = funct7[5];
      end
      7'b0010011: if (funct3 == 3'b000) begin
        reg_we      = 1'b1;
        alu_use_imm = 1'b1;
      end
      7'b0000011: begin
        reg_we = 1'b1;
        wb_sel = 2'd1;
      end
      7'b0100011: mem_we = 1'b1;
      7'b1100011: is_branch = (funct3[2:1] == 2'b00);
      7'b1101111: begin
        reg_we = 1'b1;
        wb_sel = 2'd2;
        is_jal = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BRANCH_PREDICT_EN
  logic [1:0]  bht [0:BHT_ENTRIES-1];
  logic [31:0] mispredict_count;

  assign predict_taken = is_branch & bht[bht_idx][1];

  // Saturating 2-bit counter training and misprediction tally on each branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      mispredict_count <= 32'd0;
    end else if (is_branch) begin
      if (branch_taken && bht[bht_idx] != 2'b11)      bht[bht_idx] <= bht[bht_idx] + 2'd1;
      else if (!branch_taken && bht[bht_idx] != 2'b00) bht[bht_idx] <= bht[bht_idx] - 2'd1;
      if (predict_taken != branch_taken) mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  logic unused_predict;
  assign unused_predict = ^{clk, reset, bht_idx, branch_taken};
  assign predict_taken  = 1'b0;
`endif
endmodule

module riscv_bp_cpu #(
  parameter int IMEM_DEPTH  = 256,
  parameter int DMEM_DEPTH  = 256,
  parameter int BHT_ENTRIES = 16
) (
  input logic clk,
  input logic reset
);
  localparam int DAW  = $clog2(DMEM_DEPTH);
  localparam int IDXW = $clog2(BHT_ENTRIES);

  logic [31:0] pc, instr, next_pc, pc_plus4;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, alu_f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_y, mem_addr, load_val, wd;
  logic        reg_we, mem_we, is_branch, is_jal, alu_use_imm, alu_sub;
  logic        predict_taken, branch_taken;
  logic [1:0]  wb_sel;
  logic [31:0] dmem [0:DMEM_DEPTH-1];
  logic        unused_addr;

  riscv_bp_fetch #(.IMEM_DEPTH(IMEM_DEPTH)) IF (
    .clk(clk), .reset(reset), .next_pc(next_pc), .pc(pc), .instr(instr)
  );

  riscv_bp_decode ID (
    .instr(instr), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7),
    .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b), .imm_j(imm_j)
  );

  riscv_bp_regfile RF (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .we(reg_we), .wd(wd), .rd1(rs1_val), .rd2(rs2_val)
  );

  riscv_bp_control #(.BHT_ENTRIES(BHT_ENTRIES)) CU (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .bht_idx(pc[IDXW+1:2]), .branch_taken(branch_taken),
    .reg_we(reg_we), .mem_we(mem_we), .wb_sel(wb_sel), .is_branch(is_branch),
    .is_jal(is_jal), .alu_use_imm(alu_use_imm), .alu_sub(alu_sub),
    .alu_f3(alu_f3), .predict_taken(predict_taken)
  );

  riscv_bp_alu ALU (
    .a(rs1_val), .b(alu_use_imm ? imm_i : rs2_val),
    .funct3(alu_f3), .sub(alu_sub), .y(alu_y)
  );

  assign pc_plus4     = pc + 32'd4;
  assign mem_addr     = rs1_val + (mem_we ? imm_s : imm_i);
  assign load_val     = dmem[mem_addr[DAW+1:2]];
  assign branch_taken = is_branch & (funct3[0] ? (rs1_val != rs2_val) : (rs1_val == rs2_val));
  assign next_pc      = is_jal ? (pc + imm_j) : branch_taken ? (pc + imm_b) : pc_plus4;
  assign wd           = (wb_sel == 2'd1) ? load_val : (wb_sel == 2'd2) ? pc_plus4 : alu_y;
  assign unused_addr  = ^{mem_addr[31:DAW+2], mem_addr[1:0], predict_taken};

  // Data memory store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) dmem[mem_addr[DAW+1:2]] <= rs2_val;
  end
endmodule

// File: tb/tb_riscv_bp_cpu.sv
// tb_riscv_bp_cpu: directed bench for riscv_bp_cpu. Programs and registers are
// preloaded through hierarchy; results are compared with hand-computed values.
// Expectations for the predictor follow the BRANCH_PREDICT_EN macro.

module tb_riscv_bp_cpu;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  riscv_bp_cpu dut (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.IF.memory[i] = 32'd0;
  endtask

  // Holds reset for two edges and releases it just after an edge.
  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    dut.RF.registers[9] = 32'h1234_5678;
    apply_reset();
    check32("reset_pc", dut.IF.pc, 32'd0);
    check32("reset_x9", dut.RF.registers[9], 32'd0);
  endtask

  task automatic test_arith_program();
    clear_imem();
    dut.IF.memory[0] = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3);
    dut.IF.memory[1] = r_type(7'b0, 5'd1, 5'd3, 3'b000, 5'd4);
    dut.IF.memory[2] = 32'd0;
    dut.IF.memory[3] = s_type(12'd2, 5'd4, 5'd3);
    dut.IF.memory[4] = b_type(13'd0, 5'd2, 5'd1, 3'b000);
    apply_reset();
    dut.RF.registers[1] = 32'd1;
    dut.RF.registers[2] = 32'd3;
    run_cycles(1);
    check32("arith_pc1", dut.IF.pc, 32'd4);
    check32("arith_x3_early", dut.RF.registers[3], 32'd4);
    run_cycles(3);
    check32("arith_pc4", dut.IF.pc, 32'd16);
    check32("beq_predict_first", {31'd0, dut.CU.predict_taken}, 32'd0);
    run_cycles(6);
    check32("arith_x3", dut.RF.registers[3], 32'd4);
    check32("arith_x4", dut.RF.registers[4], 32'd5);
    check32("arith_pc10", dut.IF.pc, 32'd40);
    check32("sw_offset_store", dut.dmem[1], 32'd5);
  endtask

  task automatic test_branch_predict();
    clear_imem();
    dut.IF.memory[0] = b_type(13'd8, 5'd1, 5'd1, 3'b000);
    dut.IF.memory[2] = j_type(-21'sd8, 5'd8);
    apply_reset();
    dut.RF.registers[1] = 32'd1;
    check32("bp_predict_first", {31'd0, dut.CU.predict_taken}, 32'd0);
    run_cycles(1);
    check32("bp_taken_pc", dut.IF.pc, 32'd8);
    run_cycles(1);
    check32("jal_pc", dut.IF.pc, 32'd0);
    check32("jal_link", dut.RF.registers[8], 32'd12);
    run_cycles(2);
    check32("bp_pc_second", dut.IF.pc, 32'd0);
`ifdef BRANCH_PREDICT_EN
    check32("bp_counter", {30'd0, dut.CU.bht[0]}, 32'd3);
    check32("bp_predict_trained", {31'd0, dut.CU.predict_taken}, 32'd1);
    check32("bp_mispredicts", dut.CU.mispredict_count, 32'd1);
`else
    check32("bp_predict_static", {31'd0, dut.CU.predict_taken}, 32'd0);
`endif
  endtask

  task automatic test_load_store();
    clear_imem();
    dut.IF.memory[0] = s_type(12'd0, 5'd2, 5'd0);
    dut.IF.memory[1] = i_type(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011);
    apply_reset();
    dut.RF.registers[2] = 32'hDEAD_BEEF;
    run_cycles(2);
    check32("lw_x5", dut.RF.registers[5], 32'hDEAD_BEEF);
  endtask

  task automatic test_alu_ops();
    clear_imem();
    dut.IF.memory[0] = i_type(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);
    dut.IF.memory[1] = r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd6);
    dut.IF.memory[2] = r_type(7'b0, 5'd1, 5'd6, 3'b010, 5'd7);
    dut.IF.memory[3] = i_type(12'hFFF, 5'd0, 3'b000, 5'd8, 7'b0010011);
    dut.IF.memory[4] = r_type(7'b0, 5'd2, 5'd8, 3'b101, 5'd9);
    dut.IF.memory[5] = r_type(7'b0, 5'd2, 5'd1, 3'b001, 5'd10);
    dut.IF.memory[6] = 32'hFFFF_FFFF;
    apply_reset();
    dut.RF.registers[1] = 32'd1;
    dut.RF.registers[2] = 32'd3;
    run_cycles(7);
    check32("addi_x0", dut.RF.registers[0], 32'd0);
    check32("sub_x6", dut.RF.registers[6], 32'hFFFF_FFFE);
    check32("slt_x7", dut.RF.registers[7], 32'd1);
    check32("addi_neg_x8", dut.RF.registers[8], 32'hFFFF_FFFF);
    check32("srl_x9", dut.RF.registers[9], 32'h1FFF_FFFF);
    check32("sll_x10", dut.RF.registers[10], 32'd8);
    check32("unknown_nop_pc", dut.IF.pc, 32'd28);
  endtask

  task automatic test_mid_reset();
    clear_imem();
    dut.IF.memory[0] = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3);
    dut.IF.memory[1] = r_type(7'b0, 5'd1, 5'd3, 3'b000, 5'd4);
    dut.IF.memory[3] = s_type(12'd2, 5'd4, 5'd3);
    apply_reset();
    dut.dmem[1] = 32'd0;
    dut.RF.registers[1] = 32'd1;
    dut.RF.registers[2] = 32'd3;
    run_cycles(4);
    reset = 1'b1;
    run_cycles(1);
    reset = 1'b0;
    check32("mid_reset_pc", dut.IF.pc, 32'd0);
    check32("mid_reset_x4", dut.RF.registers[4], 32'd0);
    check32("mid_reset_x1", dut.RF.registers[1], 32'd0);
    check32("mid_reset_dmem", dut.dmem[1], 32'd5);
    check32("mid_reset_imem", dut.IF.memory[0], 32'h0020_81B3);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    test_reset();
    test_arith_program();
    test_branch_predict();
    test_load_store();
    test_alu_ops();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
